// File: rtl/ahb_slave_controller.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_controller
// Description : AHB-Lite slave sequencer for a 16-byte register/buffer map.
//               Captures the address phase, gates buffer access on occupancy,
//               and generates wait states and two-cycle ERROR responses.
//               Optional wait-state timeout: define AHB_WAIT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_controller #(
    parameter int BUF_DEPTH = 64,
    parameter int MAX_WAIT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsel,
    input  logic [1:0] htrans,
    input  logic       hwrite,
    input  logic [1:0] hsize,
    input  logic [3:0] haddr,
    input  logic [3:0] value_location,
    input  logic [6:0] buffer_occupancy,
    output logic [3:0] haddr_reg,
    output logic [1:0] hsize_reg,
    output logic       hwrite_reg,
    output logic       hreadyout,
    output logic       hresp,
    output logic [3:0] reg_sel,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic       buf_push,
    output logic       buf_pop,
    output logic [2:0] num_bytes
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    localparam logic [7:0] c_buf_depth = 8'(BUF_DEPTH);
    localparam logic [3:0] c_sel_none  = 4'd7;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       w_accept;
    logic       w_err;
    logic       w_unmapped;
    logic       w_read_only;
    logic       w_is_buf;
    logic       w_rd_ready;
    logic       w_wr_ready;
    logic       w_ready;
    logic       w_xfer_ok;
    logic       w_timeout;
    logic [7:0] w_occ;
    logic [7:0] w_need;

    assign num_bytes = (hsize_reg == 2'd0) ? 3'd1 :
                       (hsize_reg == 2'd1) ? 3'd2 : 3'd4;

    assign w_occ  = {1'b0, buffer_occupancy};
    assign w_need = {5'd0, num_bytes};

    // Guard against an occupancy above capacity so the subtraction cannot wrap.
    assign w_rd_ready = (w_occ >= w_need);
    assign w_wr_ready = (w_occ <= c_buf_depth) && ((c_buf_depth - w_occ) >= w_need);
    assign w_is_buf   = (value_location[3:2] == 2'b00);
    assign w_ready    = !w_is_buf || (hwrite_reg ? w_wr_ready : w_rd_ready);

    // 0x9-0xB and 0xE-0xF are unmapped; 0x4-0x7 hold the read-only status block.
    assign w_unmapped  = (haddr_reg == 4'h9) || (haddr_reg[3:1] == 3'b101) ||
                         (haddr_reg[3:1] == 3'b111);
    assign w_read_only = (haddr_reg[3:2] == 2'b01);
    assign w_err       = (hsize_reg == 2'd3) || w_unmapped || (hwrite_reg && w_read_only);

    assign w_accept = hsel && htrans[1] && hreadyout;

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        w_xfer_ok = 1'b0;
        reg_sel   = c_sel_none;
        case (r_state)
            S_DATA: begin
                reg_sel   = value_location;
                hreadyout = !w_err && w_ready;
                w_xfer_ok = !w_err && w_ready;
            end
            S_WAIT: begin
                reg_sel   = value_location;
                hreadyout = w_ready;
                w_xfer_ok = w_ready;
            end
            S_ERR1: begin
                hresp     = 1'b1;
                hreadyout = 1'b0;
            end
            S_ERR2: begin
                hresp     = 1'b1;
            end
            default: begin
                hreadyout = 1'b1;
            end
        endcase
    end

    assign reg_wr_en = w_xfer_ok && hwrite_reg;
    assign reg_rd_en = w_xfer_ok && !hwrite_reg;
    assign buf_push  = w_xfer_ok && w_is_buf && hwrite_reg;
    assign buf_pop   = w_xfer_ok && w_is_buf && !hwrite_reg;

`ifdef AHB_WAIT_TIMEOUT_EN
    localparam logic [3:0] c_wait_last = 4'(MAX_WAIT - 1);
    logic [3:0] r_wait_cnt;

    assign w_timeout = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if ((r_state == S_WAIT) && (w_next == S_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= 4'd0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = w_accept ? S_DATA : S_IDLE;
            S_DATA: begin
                if (w_err)        w_next = S_ERR1;
                else if (w_ready) w_next = w_accept ? S_DATA : S_IDLE;
                else              w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_ready)        w_next = w_accept ? S_DATA : S_IDLE;
                else if (w_timeout) w_next = S_ERR1;
                else                w_next = S_WAIT;
            end
            S_ERR1: w_next = S_ERR2;
            S_ERR2: w_next = w_accept ? S_DATA : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            haddr_reg  <= 4'd0;
            hsize_reg  <= 2'd0;
            hwrite_reg <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                haddr_reg  <= haddr;
                hsize_reg  <= hsize;
                hwrite_reg <= hwrite;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_controller
// Description : Directed scoreboard bench for ahb_slave_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsel;
    logic [1:0] htrans;
    logic       hwrite;
    logic [1:0] hsize;
    logic [3:0] haddr;
    logic [3:0] value_location;
    logic [6:0] buffer_occupancy;
    logic [3:0] haddr_reg;
    logic [1:0] hsize_reg;
    logic       hwrite_reg;
    logic       hreadyout;
    logic       hresp;
    logic [3:0] reg_sel;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic       buf_push;
    logic       buf_pop;
    logic [2:0] num_bytes;

    localparam logic [2:0] NB_X = 3'b111;

    typedef struct packed {
        logic       rdy;
        logic       resp;
        logic       wr;
        logic       rd;
        logic       push;
        logic       pop;
        logic [3:0] sel;
        logic [2:0] nb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Simple decoder model: the four buffer addresses share code 0.
    assign value_location = (haddr_reg < 4'd4) ? 4'd0 : haddr_reg;

    ahb_slave_controller dut (
        .clk              (clk),
        .rst              (rst),
        .hsel             (hsel),
        .htrans           (htrans),
        .hwrite           (hwrite),
        .hsize            (hsize),
        .haddr            (haddr),
        .value_location   (value_location),
        .buffer_occupancy (buffer_occupancy),
        .haddr_reg        (haddr_reg),
        .hsize_reg        (hsize_reg),
        .hwrite_reg       (hwrite_reg),
        .hreadyout        (hreadyout),
        .hresp            (hresp),
        .reg_sel          (reg_sel),
        .reg_wr_en        (reg_wr_en),
        .reg_rd_en        (reg_rd_en),
        .buf_push         (buf_push),
        .buf_pop          (buf_pop),
        .num_bytes        (num_bytes)
    );

    task automatic drive(input logic s, input logic [1:0] t, input logic w,
                         input logic [1:0] sz, input logic [3:0] a);
        hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a;
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'b00, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic expect_c(input logic rdy, input logic resp, input logic wr,
                            input logic rd, input logic push, input logic pop,
                            input logic [3:0] sel, input logic [2:0] nb);
        exp_t e;
        e = '{rdy: rdy, resp: resp, wr: wr, rd: rd, push: push, pop: pop, sel: sel, nb: nb};
        sb.push_back(e);
    endtask

    task automatic idle_exp();
        expect_c(1, 0, 0, 0, 0, 0, 4'd7, NB_X);
    endtask

    task automatic step(input string tag);
        exp_t e;
        exp_t a;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            a = {hreadyout, hresp, reg_wr_en, reg_rd_en, buf_push, buf_pop, reg_sel, num_bytes};
            if (e.nb == NB_X) a.nb = NB_X;
            assert (a === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, a, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        buffer_occupancy = 7'd0;
        drive_idle();
        @(negedge clk);
        chk("rst_ready", {7'd0, hreadyout}, 8'd1);
        chk("rst_hresp", {7'd0, hresp}, 8'd0);
        chk("rst_regs", {1'b0, haddr_reg, hsize_reg, hwrite_reg}, 8'd0);
        chk("rst_sel", {4'd0, reg_sel}, 8'd7);
        chk("rst_strobes", {4'd0, reg_wr_en, reg_rd_en, buf_push, buf_pop}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Word read at 0x0 with 8 bytes available
        buffer_occupancy = 7'd8;
        drive(1, 2'b10, 0, 2'd2, 4'h0);
        idle_exp(); step("t1_addr");
        drive_idle();
        expect_c(1, 0, 0, 1, 0, 1, 4'd0, 3'd4); step("t1_data");
        idle_exp(); step("t1_idle");

        // Byte read from empty buffer; a pending request must wait for hreadyout
        buffer_occupancy = 7'd0;
        drive(1, 2'b10, 0, 2'd0, 4'h0);
        idle_exp(); step("t2_addr");
        drive(1, 2'b10, 0, 2'd2, 4'hC);
        expect_c(0, 0, 0, 0, 0, 0, 4'd0, 3'd1); step("t2_data");
        expect_c(0, 0, 0, 0, 0, 0, 4'd0, 3'd1); step("t2_wait1");
        expect_c(0, 0, 0, 0, 0, 0, 4'd0, 3'd1); step("t2_wait2");
        buffer_occupancy = 7'd1;
        expect_c(1, 0, 0, 1, 0, 1, 4'd0, 3'd1); step("t2_ready");
        drive_idle();
        expect_c(1, 0, 0, 1, 0, 0, 4'hC, 3'd4); step("t2_pipe");
        idle_exp(); step("t2_idle");

        // Half write to read-only 0x4
        drive(1, 2'b10, 1, 2'd1, 4'h4);
        idle_exp(); step("t3_addr");
        drive_idle();
        expect_c(0, 0, 0, 0, 0, 0, 4'h4, NB_X); step("t3_data");
        expect_c(0, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t3_err1");
        expect_c(1, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t3_err2");
        idle_exp(); step("t3_idle");

        // Read unmapped 0xE, then illegal size at 0x0 accepted during ERR2
        buffer_occupancy = 7'd8;
        drive(1, 2'b10, 0, 2'd2, 4'hE);
        idle_exp(); step("t4_addr");
        drive_idle();
        expect_c(0, 0, 0, 0, 0, 0, 4'hE, NB_X); step("t4_data");
        expect_c(0, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t4_err1");
        drive(1, 2'b11, 0, 2'd3, 4'h0);
        expect_c(1, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t4_err2");
        drive_idle();
        expect_c(0, 0, 0, 0, 0, 0, 4'd0, NB_X); step("t4b_data");
        expect_c(0, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t4b_err1");
        expect_c(1, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t4b_err2");
        idle_exp(); step("t4b_idle");

        // Back-to-back: write 0xC then read 0x8
        drive(1, 2'b10, 1, 2'd2, 4'hC);
        idle_exp(); step("t5_addr");
        drive(1, 2'b10, 0, 2'd2, 4'h8);
        expect_c(1, 0, 1, 0, 0, 0, 4'hC, 3'd4); step("t5_wr");
        drive_idle();
        expect_c(1, 0, 0, 1, 0, 0, 4'h8, 3'd4); step("t5_rd");
        idle_exp(); step("t5_idle");

        // Free-space and occupancy boundaries
        buffer_occupancy = 7'd62;
        drive(1, 2'b10, 1, 2'd1, 4'h0);
        idle_exp(); step("t6_addr_half");
        buffer_occupancy = 7'd60;
        drive(1, 2'b10, 1, 2'd2, 4'h0);
        buffer_occupancy = 7'd62;
        expect_c(1, 0, 1, 0, 1, 0, 4'd0, 3'd2); step("t6_half_at62");
        drive(1, 2'b10, 0, 2'd2, 4'h0);
        buffer_occupancy = 7'd60;
        expect_c(1, 0, 1, 0, 1, 0, 4'd0, 3'd4); step("t6_word_at60");
        drive_idle();
        buffer_occupancy = 7'd3;
        expect_c(0, 0, 0, 0, 0, 0, 4'd0, 3'd4); step("t6_rd_at3");
        buffer_occupancy = 7'd4;
        expect_c(1, 0, 0, 1, 0, 1, 4'd0, 3'd4); step("t6_rd_at4");
        idle_exp(); step("t6_idle");

        // IDLE/BUSY transfer types and deselected NONSEQ are ignored
        drive(1, 2'b01, 1, 2'd2, 4'hC);
        idle_exp(); step("t7_busy");
        drive(1, 2'b00, 1, 2'd2, 4'hC);
        idle_exp(); step("t7_idle");
        drive(0, 2'b10, 1, 2'd2, 4'hC);
        idle_exp(); step("t7_nosel");
        drive_idle();
        idle_exp(); step("t7_after");

        // Reset mid-WAIT aborts without a strobe
        buffer_occupancy = 7'd0;
        drive(1, 2'b10, 0, 2'd2, 4'h4);
        idle_exp(); step("t8_addr");
        drive_idle();
        expect_c(1, 0, 0, 1, 0, 0, 4'h4, 3'd4); step("t8_status_rd");
        drive(1, 2'b10, 0, 2'd2, 4'h0);
        idle_exp(); step("t8_addr2");
        drive_idle();
        expect_c(0, 0, 0, 0, 0, 0, 4'd0, 3'd4); step("t8_data");
        expect_c(0, 0, 0, 0, 0, 0, 4'd0, 3'd4); step("t8_wait");
        buffer_occupancy = 7'd8;
        rst = 1'b1;
        expect_c(1, 0, 0, 0, 0, 0, 4'd7, NB_X); step("t8_reset");
        chk("t8_haddr_cleared", {4'd0, haddr_reg}, 8'd0);
        rst = 1'b0;
        idle_exp(); step("t8_idle");

`ifdef AHB_WAIT_TIMEOUT_EN
        // Word write with 62 bytes held: wait limit then ERROR
        buffer_occupancy = 7'd62;
        drive(1, 2'b10, 1, 2'd2, 4'h0);
        idle_exp(); step("t9_addr");
        drive_idle();
        for (int i = 0; i < 16; i++) begin
            expect_c(0, 0, 0, 0, 0, 0, 4'd0, 3'd4);
            step("t9_wait");
        end
        expect_c(0, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t9_err1");
        expect_c(1, 1, 0, 0, 0, 0, 4'd7, NB_X); step("t9_err2");
        idle_exp(); step("t9_idle");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
